// File: rtl/decode_stage.sv
// Instruction decode + ID/EX register: decodes op/operands, resolves B/BEQ/BGE, tracks Z/N and pending CMPs.
// Latency: 1 cycle from accept to out_valid; br_taken/illegal pulse the cycle after accept.
// Backpressure: in_ready drops while the slot is full and not consumed, on a flag hazard, or during flush.
// Optional: DECODE_ILLEGAL_TRAP_EN enables the registered illegal-opcode pulse (otherwise illegal is tied 0).
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [3:0]  rf_ra1,
  output logic [3:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  rd,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  input  logic        flag_we,
  input  logic        flag_z,
  input  logic        flag_n,
  input  logic        flush,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LSL = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_SET = 4'h6;
  localparam logic [3:0] OP_LDR = 4'h7;
  localparam logic [3:0] OP_STR = 4'h8;
  localparam logic [3:0] OP_B   = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_BGE = 4'hB;
  localparam logic [3:0] SEL_BUBBLE = 4'hF;

  // Instruction fields
  logic [3:0]  op;
  logic        imm_sel;
  logic [31:0] imm_zx;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] mem_addr;

  assign op       = instr[31:28];
  assign imm_sel  = instr[27];
  assign imm_zx   = {17'd0, instr[14:0]};
  assign br_off   = {{5{instr[26]}}, instr[26:0]};
  assign br_tgt   = pc + br_off;
  assign mem_addr = rf_rd1 + imm_zx;
  assign rf_ra1   = instr[22:19];
  assign rf_ra2   = instr[18:15];

  // Registered state
  logic        out_valid_q, out_valid_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic [1:0]  cmp_pending_q, cmp_pending_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;

  // Decode results
  logic [3:0]  dec_sel;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_rd;
  logic        dec_we;
  logic        dec_re;
  logic        dec_mwe;
  logic        dec_taken;

  logic        hazard;
  logic        accept;
  logic        kill_cmp;

  // Translate the presented instruction into slot fields; branches resolve against the current Z/N
  always_comb begin
    dec_sel   = op;
    dec_a     = '0;
    dec_b     = '0;
    dec_rd    = instr[26:23];
    dec_we    = 1'b0;
    dec_re    = 1'b0;
    dec_mwe   = 1'b0;
    dec_taken = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LSL: begin
        dec_a  = rf_rd1;
        dec_b  = imm_sel ? imm_zx : rf_rd2;
        dec_we = 1'b1;
      end
      OP_CMP: begin
        dec_a = rf_rd1;
        dec_b = imm_sel ? imm_zx : rf_rd2;
      end
      OP_SET: begin
        dec_a  = imm_zx;
        dec_we = 1'b1;
      end
      OP_LDR: begin
        dec_a  = mem_addr;
        dec_re = 1'b1;
        dec_we = 1'b1;
      end
      OP_STR: begin
        dec_a   = mem_addr;
        dec_b   = rf_rd2;
        dec_mwe = 1'b1;
      end
      OP_B: begin
        dec_a     = br_tgt;
        dec_rd    = '0;
        dec_taken = 1'b1;
      end
      OP_BEQ: begin
        dec_a     = br_tgt;
        dec_rd    = '0;
        dec_taken = z_q;
      end
      OP_BGE: begin
        dec_a     = br_tgt;
        dec_rd    = '0;
        dec_taken = ~n_q;
      end
      default: begin
        // Unassigned opcodes travel as a bubble: no register, memory or flag effects
        dec_sel = SEL_BUBBLE;
        dec_rd  = '0;
      end
    endcase
  end

  // Conditional branches must wait for all in-flight CMPs; a fourth CMP would overflow the counter
  always_comb begin
    hazard = 1'b0;
    if (((op == OP_BEQ) || (op == OP_BGE)) && (cmp_pending_q != 2'd0)) hazard = 1'b1;
    if ((op == OP_CMP) && (cmp_pending_q == 2'd3)) hazard = 1'b1;
  end

  assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;
  assign kill_cmp = flush & out_valid_q & (alu_sel_q == OP_CMP);

  // ID/EX slot: flush wins, then load on accept, else drain on consume, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rd_d        = rd_q;
    reg_we_d    = reg_we_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_sel_d   = dec_sel;
      alu_a_d     = dec_a;
      alu_b_d     = dec_b;
      rd_d        = dec_rd;
      reg_we_d    = dec_we;
      mem_re_d    = dec_re;
      mem_we_d    = dec_mwe;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Flags follow execute's CMP writes; pending count sums accept, write-back and flush-kill events
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    if (flag_we) begin
      z_d = flag_z;
      n_d = flag_n;
    end
    cmp_pending_d = cmp_pending_q
                  + {1'b0, accept & (op == OP_CMP)}
                  - {1'b0, flag_we}
                  - {1'b0, kill_cmp};
  end

  // Taken-branch pulse for the cycle after accept; accept is already blocked during flush
  always_comb begin
    br_taken_d  = accept & dec_taken;
    br_target_d = br_target_q;
    if (accept & dec_taken) br_target_d = br_tgt;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      alu_sel_q     <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rd_q          <= '0;
      reg_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      z_q           <= 1'b0;
      n_q           <= 1'b0;
      cmp_pending_q <= '0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      alu_sel_q     <= alu_sel_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rd_q          <= rd_d;
      reg_we_q      <= reg_we_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      z_q           <= z_d;
      n_q           <= n_d;
      cmp_pending_q <= cmp_pending_d;
      br_taken_q    <= br_taken_d;
      br_target_q   <= br_target_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // One-cycle trap pulse after an unassigned opcode is accepted as a bubble
  always_comb begin
    illegal_d = accept & (op >= 4'hC);
  end

  // Trap pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rd        = rd_q;
  assign reg_we    = reg_we_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic against a behavioural model.
// Driver pushes expected slot contents and branch/trap pulses into queues; monitors pop and compare.
// Execute side is modelled: consumed CMPs later return a flag write.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr, pc;
  logic [3:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        out_valid, out_ready;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  rd;
  logic        reg_we, mem_re, mem_we;
  logic        flag_we, flag_z, flag_n;
  logic        flush;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .out_valid(out_valid), .out_ready(out_ready),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .rd(rd),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .flag_we(flag_we), .flag_z(flag_z), .flag_n(flag_n), .flush(flush),
    .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        we;
    logic        re;
    logic        mwe;
  } slot_t;

  typedef struct packed {
    logic        tk;
    logic [31:0] tg;
    logic        il;
  } br_t;

  slot_t sbq[$];
  br_t   brq[$];
  int    total = 0;
  int    bad = 0;
  // Behavioural model state
  int    pend = 0;     // CMPs accepted whose flags have not yet been written back
  int    exe_cmp = 0;  // CMPs consumed by execute and awaiting their flag write
  bit    occ = 0;
  bit    zm = 0;
  bit    nm = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic i, input logic [3:0] d,
                                     input logic [3:0] n, input logic [3:0] m, input logic [14:0] imm);
    return {op, i, d, n, m, imm};
  endfunction

  function automatic logic [31:0] mkb(input logic [3:0] op, input logic [26:0] off);
    return {op, off};
  endfunction

  function automatic logic [31:0] sext27(input logic [31:0] ins);
    logic [31:0] v;
    v = {5'd0, ins[26:0]};
    if (ins[26]) v = v - 32'h0800_0000;
    return v;
  endfunction

  // Expected slot contents straight from the instruction-set rules
  function automatic slot_t exp_of(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
    slot_t e;
    logic [31:0] imm;
    int op;
    op  = int'(ins[31:28]);
    imm = {17'd0, ins[14:0]};
    e = '0;
    e.sel = ins[31:28];
    e.rd  = ins[26:23];
    if (op <= 5) begin
      e.a  = r1;
      e.b  = ins[27] ? imm : r2;
      e.we = (op != 5);
    end else if (op == 6) begin
      e.a = imm; e.we = 1;
    end else if (op == 7) begin
      e.a = r1 + imm; e.re = 1; e.we = 1;
    end else if (op == 8) begin
      e.a = r1 + imm; e.b = r2; e.mwe = 1;
    end else if (op <= 11) begin
      e.a = p + sext27(ins); e.rd = 0;
    end else begin
      e.sel = 4'hF; e.rd = 0;
    end
    return e;
  endfunction

  // One clock of stimulus plus model update
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p, input bit ordy,
                      input bit fl, input bit fwe, input bit fz, input bit fn,
                      input logic [31:0] r1, input logic [31:0] r2);
    int op;
    bit haz, exp_rdy, acc, cons, kill, fw_eff, tk, front_cmp;
    br_t b;
    @(negedge clk);
    fw_eff    = fwe && (exe_cmp > 0);
    in_valid  = v;
    instr     = ins;
    pc        = p;
    out_ready = ordy && !fl;
    flush     = fl;
    flag_we   = fw_eff;
    flag_z    = fz;
    flag_n    = fn;
    rf_rd1    = r1;
    rf_rd2    = r2;
    #1;
    op      = int'(ins[31:28]);
    haz     = ((op == 10 || op == 11) && pend != 0) || (op == 5 && pend >= 3);
    exp_rdy = (!occ || out_ready) && !haz && !fl;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, occ});
    chk("rf_ra1", {28'd0, rf_ra1}, {28'd0, ins[22:19]});
    chk("rf_ra2", {28'd0, rf_ra2}, {28'd0, ins[18:15]});
    acc       = v && exp_rdy;
    cons      = occ && out_ready;
    kill      = fl && occ;
    front_cmp = (sbq.size() > 0) && (sbq[0].sel == 4'h5);
    if (kill) begin
      if (front_cmp) pend--;
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    if (cons && front_cmp) exe_cmp++;
    if (acc) sbq.push_back(exp_of(ins, p, r1, r2));
    tk   = acc && (op == 9 || (op == 10 && zm) || (op == 11 && !nm));
    b.tk = tk;
    b.tg = p + sext27(ins);
`ifdef DECODE_ILLEGAL_TRAP_EN
    b.il = acc && (op >= 12);
`else
    b.il = 1'b0;
`endif
    brq.push_back(b);
    if (acc && op == 5) pend++;
    if (fw_eff) begin
      pend--;
      exe_cmp--;
      zm = fz;
      nm = fn;
    end
    occ = fl ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : occ;
  endtask

  task automatic idle(input bit ordy, input bit fwe, input bit fz, input bit fn);
    step(0, 32'd0, 32'd0, ordy, 0, fwe, fz, fn, $urandom, $urandom);
  endtask

  // Slot monitor: the presented slot must match the oldest expected entry; pop on consume
  always @(negedge clk) begin
    slot_t e;
    #2;
    if (!rst && !flush && out_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL slot_unexpected: got out_valid=1 want no pending slot");
      end else begin
        e = sbq[0];
        chk("alu_sel", {28'd0, alu_sel}, {28'd0, e.sel});
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("rd", {28'd0, rd}, {28'd0, e.rd});
        chk("enables", {29'd0, reg_we, mem_re, mem_we}, {29'd0, e.we, e.re, e.mwe});
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  // Pulse monitor: br_taken/br_target/illegal reflect the previous cycle's accept
  always @(posedge clk) begin
    br_t e;
    #2;
    if (!rst && brq.size() > 0) begin
      e = brq.pop_front();
      chk("br_taken", {31'd0, br_taken}, {31'd0, e.tk});
      if (e.tk) chk("br_target", br_target, e.tg);
      chk("illegal", {31'd0, illegal}, {31'd0, e.il});
    end
  end

  initial begin
    logic [31:0] ins;
    int op;
    rst = 1'b1;
    in_valid = 0; instr = 0; pc = 0; out_ready = 0; flush = 0;
    flag_we = 0; flag_z = 0; flag_n = 0; rf_rd1 = 0; rf_rd2 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_rd", {28'd0, rd}, 32'd0);
    chk("rst_enables", {29'd0, reg_we, mem_re, mem_we}, 32'd0);
    chk("rst_br", {31'd0, br_taken}, 32'd0);
    chk("rst_br_target", br_target, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // ADD I=1 rd=2 rn=1 imm=5 with r1=10
    step(1, mk(4'h0, 1, 4'd2, 4'd1, 4'd3, 15'd5), 32'h40, 1, 0, 0, 0, 0, 32'd10, 32'd99);
    idle(1, 0, 0, 0);

    // Backpressure: slot held for 3 cycles, then consume and accept on the same edge
    step(1, mk(4'h1, 0, 4'd3, 4'd4, 4'd5, 15'd0), 32'h44, 0, 0, 0, 0, 0, 32'd7, 32'd3);
    repeat (3) step(1, mk(4'h3, 0, 4'd6, 4'd7, 4'd8, 15'd1), 32'h48, 0, 0, 0, 0, 0, $urandom, $urandom);
    step(1, mk(4'h7, 0, 4'd9, 4'd2, 4'd0, 15'h7FFF), 32'h48, 1, 0, 0, 0, 0, 32'hFFFF_F000, 32'd1);
    step(1, mk(4'h8, 1, 4'd1, 4'd2, 4'd3, 15'd16), 32'h4C, 1, 0, 0, 0, 0, 32'h100, 32'hABCD);
    step(1, mk(4'h6, 1, 4'd5, 4'd0, 4'd0, 15'h1234), 32'h50, 1, 0, 0, 0, 0, $urandom, $urandom);
    idle(1, 0, 0, 0);

    // CMP then BEQ: stall until flag write with Z=1, then taken
    step(1, mk(4'h5, 0, 4'd0, 4'd1, 4'd2, 15'd0), 32'h60, 1, 0, 0, 0, 0, 32'd4, 32'd4);
    step(1, mkb(4'hA, 27'd32), 32'h64, 1, 0, 0, 0, 0, 0, 0);
    step(1, mkb(4'hA, 27'd32), 32'h64, 1, 0, 1, 1, 0, 0, 0);
    step(1, mkb(4'hA, 27'd32), 32'h64, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0);

    // BGE pc=0x100 offset -8: not taken with N=1, taken with N=0
    step(1, mk(4'h5, 1, 4'd0, 4'd1, 4'd0, 15'd9), 32'h70, 1, 0, 0, 0, 0, 32'd1, 0);
    idle(1, 0, 0, 0);
    idle(1, 1, 0, 1);
    step(1, mkb(4'hB, 27'h7FFFFF8), 32'h100, 1, 0, 0, 0, 0, 0, 0);
    step(1, mk(4'h5, 1, 4'd0, 4'd1, 4'd0, 15'd0), 32'h104, 1, 0, 0, 0, 0, 32'd1, 0);
    idle(1, 0, 0, 0);
    idle(1, 1, 0, 0);
    step(1, mkb(4'hB, 27'h7FFFFF8), 32'h100, 1, 0, 0, 0, 0, 0, 0);
    step(1, mkb(4'h9, 27'h4000000), 32'h10, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0);

    // Flush a CMP sitting in ID/EX: the following BEQ goes straight in
    step(1, mk(4'h5, 0, 4'd0, 4'd1, 4'd2, 15'd0), 32'h80, 0, 0, 0, 0, 0, 32'd5, 32'd6);
    step(1, mkb(4'hA, 27'd8), 32'h84, 0, 1, 0, 0, 0, 0, 0);
    step(1, mkb(4'hA, 27'd8), 32'h84, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0);

    // Illegal opcode becomes a bubble
    step(1, mk(4'hD, 1, 4'd7, 4'd3, 4'd4, 15'h55), 32'h90, 1, 0, 0, 0, 0, 32'd11, 32'd12);
    idle(1, 0, 0, 0);

    // Three CMPs in flight: a fourth must wait
    step(1, mk(4'h5, 0, 4'd0, 4'd1, 4'd2, 15'd0), 32'hA0, 1, 0, 0, 0, 0, 1, 2);
    step(1, mk(4'h5, 0, 4'd0, 4'd1, 4'd2, 15'd0), 32'hA4, 1, 0, 0, 0, 0, 3, 4);
    step(1, mk(4'h5, 0, 4'd0, 4'd1, 4'd2, 15'd0), 32'hA8, 1, 0, 0, 0, 0, 5, 6);
    step(1, mk(4'h5, 0, 4'd0, 4'd1, 4'd2, 15'd0), 32'hAC, 1, 0, 0, 0, 0, 7, 8);
    repeat (5) idle(1, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      op  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) op = 5;
      if ($urandom_range(0, 3) == 0) op = $urandom_range(9, 11);
      ins[31:28] = op[3:0];
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom);
    end
    repeat (10) idle(1, 1, 0, 0);

    // Reset while a slot is full drops it
    step(1, mk(4'h2, 0, 4'd1, 4'd2, 4'd3, 15'd0), 32'hC0, 0, 0, 0, 0, 0, 32'hF0, 32'h3C);
    @(negedge clk);
    in_valid = 0; out_ready = 0; instr = 0;
    rst = 1'b1;
    sbq.delete(); brq.delete();
    pend = 0; exe_cmp = 0; occ = 0; zm = 0; nm = 0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step(1, mk(4'h0, 1, 4'd4, 4'd1, 4'd0, 15'd1), 32'hD0, 1, 0, 0, 0, 0, 32'd2, 0);
    idle(1, 0, 0, 0);
    idle(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
